sort_ram_reader: RTL

// - Read-out side of the 16x8 sort RAM: after the bubble sorter finishes, this block walks addresses 0..DEPTH-1.
// - Streams each byte out on a VALIDQ/READY handshake to a display or serial sink.
// - Checks non-strict ascending order and reports SORTEDQ plus the first offending index.
// - Owns the RAM address and read port while BUSYQ=1; the sorter must be idle during a read-out.

---
 rtl/sort_ram_reader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sort_ram_reader.sv
// rtl/sort_ram_reader.sv - streams the sort RAM out in address order and checks for ascending order
//
// Purpose
//   After the bubble sorter has finished, this block walks RAM addresses
//   0..DEPTH-1. Each word is presented on a VALIDQ/READY handshake, and the
//   stream is checked for non-strict ascending order. While BUSYQ=1 the block
//   owns the RAM address and read port.
//
// Ports
//   C         in   1   clock
//   R         in   1   synchronous active-high reset, priority over all inputs
//   START     in   1   one-cycle read-out request, ignored while busy
//   ADDRQ     out  AW  registered RAM read address
//   RAMQ      in   DW  RAM read data, valid RD_LAT edges after ADDRQ settles
//   DATAQ     out  DW  registered output byte
//   VALIDQ    out  1   DATAQ valid, held until accepted
//   READY     in   1   sink accepts DATAQ on an edge with VALIDQ&READY
//   BUSYQ     out  1   read-out in progress
//   DONEQ     out  1   one-cycle pulse after the last byte is accepted
//   SORTEDQ   out  1   1 if the last completed read-out was ascending
//   ERR_IDXQ  out  AW  first index i with DATA[i] < DATA[i-1], 0 if sorted
//   CHKSUMQ   out  DW  mod-2**DW sum of accepted bytes (optional)
//
// Configuration
//   SORT_RAM_READER_CHKSUM_EN : when defined, adds CHKSUMQ and its adder.
module sort_ram_reader #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          C,
  input  logic          R,
  input  logic          START,
  output logic [AW-1:0] ADDRQ,
  input  logic [DW-1:0] RAMQ,
  output logic [DW-1:0] DATAQ,
  output logic          VALIDQ,
  input  logic          READY,
  output logic          BUSYQ,
  output logic          DONEQ,
  output logic          SORTEDQ,
`ifdef SORT_RAM_READER_CHKSUM_EN
  output logic [AW-1:0] ERR_IDXQ,
  output logic [DW-1:0] CHKSUMQ
`else
  output logic [AW-1:0] ERR_IDXQ
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  // FETCH spans RD_LAT+1 cycles: RD_LAT for the RAM plus one to capture.
  localparam logic [1:0]    LAST_CNT  = 2'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q,   state_d;
  logic [1:0]    cnt_q,     cnt_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [DW-1:0] data_q,    data_d;
  logic          valid_q,   valid_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          sorted_q,  sorted_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  // Working order-check state for the read-out in progress.
  logic          err_q,     err_d;
  logic [AW-1:0] idx_q,     idx_d;
  logic [DW-1:0] prev_q,    prev_d;
`ifdef SORT_RAM_READER_CHKSUM_EN
  logic [DW-1:0] chk_q,     chk_d;
`endif

  logic accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sorted_d  = sorted_q;
    err_idx_d = err_idx_q;
    err_d     = err_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
`ifdef SORT_RAM_READER_CHKSUM_EN
    chk_d     = chk_q;
`endif
    accept    = (state_q == S_PRESENT) && valid_q && READY;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SORT_RAM_READER_CHKSUM_EN
          chk_d   = '0;
`endif
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (cnt_q == LAST_CNT) begin
          data_d  = RAMQ;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_PRESENT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_PRESENT: begin
        if (accept) begin
          valid_d = 1'b0;
          // Only the first descent is recorded; index 0 has no predecessor.
          if ((addr_q != '0) && (data_q < prev_q) && !err_q) begin
            err_d = 1'b1;
            idx_d = addr_q;
          end
          prev_d = data_q;
`ifdef SORT_RAM_READER_CHKSUM_EN
          chk_d  = chk_q + data_q;
`endif
          if (addr_q == LAST_ADDR) begin
            // DONEQ is registered so it is high exactly while in DONE.
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            cnt_d   = '0;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        sorted_d  = !err_q;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        addr_d    = '0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sorted_q  <= 1'b0;
      err_idx_q <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      prev_q    <= '0;
`ifdef SORT_RAM_READER_CHKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sorted_q  <= sorted_d;
      err_idx_q <= err_idx_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
`ifdef SORT_RAM_READER_CHKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign ADDRQ    = addr_q;
  assign DATAQ    = data_q;
  assign VALIDQ   = valid_q;
  assign BUSYQ    = busy_q;
  assign DONEQ    = done_q;
  assign SORTEDQ  = sorted_q;
  assign ERR_IDXQ = err_idx_q;
`ifdef SORT_RAM_READER_CHKSUM_EN
  assign CHKSUMQ  = chk_q;
`endif

endmodule
